dffram_rw_init: RTL and testbench

- Parametrised successor to the team's single-port DFF RAM.
- Generalises data width, depth and byte-lane count.
- Adds four things the single-port RAM lacks:
  - valid/ready request handshake;
  - selectable read latency (1 or 2 cycles) with a read-valid strobe;
  - selectable read-during-write mode;
  - a post-reset hardware clear sweep that zeroes every word before the first request is accepted.
- Sits between the RV32i multicycle core (or SPI bridge) and on-chip data/instruction storage.

---
 rtl/dffram_rw_init_if.sv | 30 +++
 rtl/dffram_rw_init.sv | 122 ++++++++++++
 tb/tb_dffram_rw_init.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dffram_rw_init_if.sv
// Request/response bundle for dffram_rw_init: requester drives the request side,
// the RAM drives ready, read data, read-valid strobe and init status.
interface dffram_rw_init_if #(
    parameter int ADDRESS_LENGTH = 11,
    parameter int DATA_LENGTH    = 32
);
    localparam int NB = DATA_LENGTH / 8;

    // A request transfers on a rising edge where REQ_VALID && REQ_READY; the
    // requester holds EN/WE/A/Di stable until then, and REQ_VALID never waits on REQ_READY.
    logic                      EN;
    logic                      REQ_VALID;
    logic                      REQ_READY;
    logic [NB-1:0]             WE;
    logic [ADDRESS_LENGTH-1:0] A;
    logic [DATA_LENGTH-1:0]    Di;
    logic [DATA_LENGTH-1:0]    Do;
    logic                      RVALID;
    logic                      INIT_DONE;

    modport master (
        output EN, REQ_VALID, WE, A, Di,
        input  REQ_READY, Do, RVALID, INIT_DONE
    );

    modport slave (
        input  EN, REQ_VALID, WE, A, Di,
        output REQ_READY, Do, RVALID, INIT_DONE
    );
endinterface

// File: rtl/dffram_rw_init.sv
// Parametrised byte-lane DFF RAM with valid/ready requests, 1- or 2-cycle read
// latency, selectable read-during-write behaviour and a post-reset zeroing sweep.
module dffram_rw_init #(
    parameter int ADDRESS_LENGTH = 11,
    parameter int DATA_LENGTH    = 32,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int ZERO_IDLE      = 1,
    parameter int INIT_CLEAR     = 1
) (
    input  logic                CLK,
    input  logic                RST,
    dffram_rw_init_if.slave     bus,
    output logic                DBG_STATE
);
    localparam int NB    = DATA_LENGTH / 8;
    localparam int DEPTH = 2 ** ADDRESS_LENGTH;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDRESS_LENGTH-1:0] cnt_q, cnt_d;
    logic                      init_done_q, init_done_d;
    logic                      sweep_we;
    logic                      ready;
    logic                      accept;

    logic [DATA_LENGTH-1:0]    mem [DEPTH];
    logic [DATA_LENGTH-1:0]    old_word;
    logic [DATA_LENGTH-1:0]    merged_word;
    logic [DATA_LENGTH-1:0]    resp_word;

    logic                      v1_q, v2_q;
    logic [DATA_LENGTH-1:0]    d1_q, d2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        sweep_we    = 1'b0;
        ready       = 1'b0;
        case (state_q)
            S_INIT: begin
                if (INIT_CLEAR != 0) begin
                    sweep_we = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == {ADDRESS_LENGTH{1'b1}}) begin
                        state_d     = S_RUN;
                        init_done_d = 1'b1;
                    end
                end else begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                ready = bus.EN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign accept = bus.REQ_VALID & ready;

    // Old word and byte-merged word are both formed from the pre-edge array;
    // WRITE_FIRST picks which one becomes the response.
    always_comb begin
        old_word    = mem[bus.A];
        merged_word = old_word;
        for (int k = 0; k < NB; k++) begin
            if (bus.WE[k]) merged_word[8*k +: 8] = bus.Di[8*k +: 8];
        end
        resp_word = (WRITE_FIRST != 0) ? merged_word : old_word;
    end

    // Storage has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge CLK) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.WE[k]) mem[bus.A][8*k +: 8] <= bus.Di[8*k +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            v2_q <= 1'b0;
            d2_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept)              d1_q <= resp_word;
            else if (ZERO_IDLE != 0) d1_q <= '0;
            v2_q <= v1_q;
            if (v1_q)                d2_q <= d1_q;
            else if (ZERO_IDLE != 0) d2_q <= '0;
        end
    end

    assign bus.REQ_READY = ready;
    assign bus.RVALID    = (READ_LATENCY == 2) ? v2_q : v1_q;
    assign bus.Do        = (READ_LATENCY == 2) ? d2_q : d1_q;
    assign bus.INIT_DONE = init_done_q;
    assign DBG_STATE     = (state_q == S_RUN);
endmodule

// File: tb/tb_dffram_rw_init.sv
// Bench for dffram_rw_init: a read-first latency-1 instance and a write-first
// latency-2 instance share one request stream and one reference memory.
module tb_dffram_rw_init;
  localparam int AL    = 4;
  localparam int DL    = 32;
  localparam int NB    = DL / 8;
  localparam int DEPTH = 2 ** AL;

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          en;
  logic          req_valid;
  logic [NB-1:0] we;
  logic [AL-1:0] addr;
  logic [DL-1:0] di;
  logic          dbg_a, dbg_b;

  dffram_rw_init_if #(.ADDRESS_LENGTH(AL), .DATA_LENGTH(DL)) bus_a ();
  dffram_rw_init_if #(.ADDRESS_LENGTH(AL), .DATA_LENGTH(DL)) bus_b ();

  assign bus_a.EN = en;        assign bus_b.EN = en;
  assign bus_a.REQ_VALID = req_valid; assign bus_b.REQ_VALID = req_valid;
  assign bus_a.WE = we;        assign bus_b.WE = we;
  assign bus_a.A = addr;       assign bus_b.A = addr;
  assign bus_a.Di = di;        assign bus_b.Di = di;

  dffram_rw_init #(
    .ADDRESS_LENGTH(AL), .DATA_LENGTH(DL), .READ_LATENCY(1),
    .WRITE_FIRST(0), .ZERO_IDLE(1), .INIT_CLEAR(1)
  ) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a.slave), .DBG_STATE(dbg_a));

  dffram_rw_init #(
    .ADDRESS_LENGTH(AL), .DATA_LENGTH(DL), .READ_LATENCY(2),
    .WRITE_FIRST(1), .ZERO_IDLE(1), .INIT_CLEAR(1)
  ) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b.slave), .DBG_STATE(dbg_b));

  // reference model and scoreboard
  logic [DL-1:0] ref_mem [DEPTH];
  logic [DL-1:0] exp_q_a[$];
  logic [DL-1:0] exp_q_b[$];
  int            due_q_a[$];
  int            due_q_b[$];
  bit            model_run;
  bit            last_accepted;
  int            sweep_cnt;
  int            cyc;
  int            vectors;
  int            miscompares;

  task automatic check(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec-level view of one clock edge: either one sweep step or one request.
  task automatic model_edge();
    logic [DL-1:0] old_w, new_w;
    last_accepted = 1'b0;
    if (RST) return;
    if (!model_run) begin
      sweep_cnt++;
      if (sweep_cnt == DEPTH) model_run = 1'b1;
    end else if (en && req_valid) begin
      last_accepted = 1'b1;
      old_w = ref_mem[addr];
      new_w = old_w;
      for (int k = 0; k < NB; k++) begin
        if (we[k]) new_w[8*k +: 8] = di[8*k +: 8];
      end
      ref_mem[addr] = new_w;
      exp_q_a.push_back(old_w);
      due_q_a.push_back(cyc);
      exp_q_b.push_back(new_w);
      due_q_b.push_back(cyc + 1);
    end
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic idone, input logic dbg);
    check({tag, "_ready"}, 32'(rdy), 32'(model_run && en && !RST));
    check({tag, "_init_done"}, 32'(idone), 32'(model_run));
    check({tag, "_state"}, 32'(dbg), 32'(model_run));
  endtask

  task automatic step();
    logic          ev;
    logic [DL-1:0] ed;
    @(posedge CLK);
    cyc++;
    model_edge();
    @(negedge CLK);
    check_status("a", bus_a.REQ_READY, bus_a.INIT_DONE, dbg_a);
    check_status("b", bus_b.REQ_READY, bus_b.INIT_DONE, dbg_b);
    ev = 1'b0; ed = '0;
    if (due_q_a.size() > 0 && due_q_a[0] == cyc) begin
      ev = 1'b1; ed = exp_q_a.pop_front(); void'(due_q_a.pop_front());
    end
    check("a_rvalid", 32'(bus_a.RVALID), 32'(ev));
    check("a_do", bus_a.Do, ed);
    ev = 1'b0; ed = '0;
    if (due_q_b.size() > 0 && due_q_b[0] == cyc) begin
      ev = 1'b1; ed = exp_q_b.pop_front(); void'(due_q_b.pop_front());
    end
    check("b_rvalid", 32'(bus_b.RVALID), 32'(ev));
    check("b_do", bus_b.Do, ed);
  endtask

  // driver tasks
  task automatic apply_reset(input int hold);
    RST = 1'b1;
    #1;
    exp_q_a.delete(); due_q_a.delete();
    exp_q_b.delete(); due_q_b.delete();
    model_run = 1'b0;
    sweep_cnt = 0;
    check("rst_a_rvalid", 32'(bus_a.RVALID), 32'd0);
    check("rst_b_rvalid", 32'(bus_b.RVALID), 32'd0);
    check("rst_a_init_done", 32'(bus_a.INIT_DONE), 32'd0);
    check("rst_b_init_done", 32'(bus_b.INIT_DONE), 32'd0);
    check("rst_b_do", bus_b.Do, '0);
    repeat (hold) step();
    RST = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_req(input logic [NB-1:0] w, input logic [AL-1:0] a, input logic [DL-1:0] d);
    en = 1'b1; req_valid = 1'b1; we = w; addr = a; di = d;
    step();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; we = '0;
    repeat (n) step();
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    en = 1'b1; req_valid = 1'b1; we = '0; addr = '0; di = '0;
    apply_reset(2);

    // sweep: request held throughout; ready must stay low for the whole sweep
    repeat (DEPTH) step();
    check("sweep_ready_after", 32'(bus_a.REQ_READY), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      addr = AL'(i);
      step();
      check("sweep_zero_a", bus_a.Do, '0);
    end
    idle(2);

    // byte enables
    do_req(4'b1111, 4'd5, 32'hAABBCCDD);
    do_req(4'b0101, 4'd5, 32'h11223344);
    do_req(4'b0000, 4'd5, 32'h0);
    check("be_read_a", bus_a.Do, 32'hAA22CC44);
    idle(1);
    check("be_read_b", bus_b.Do, 32'hAA22CC44);
    idle(1);

    // read-during-write
    do_req(4'b1111, 4'd3, 32'h12345678);
    do_req(4'b0011, 4'd3, 32'hFFFFFFFF);
    check("rdw_read_first", bus_a.Do, 32'h12345678);
    idle(1);
    check("rdw_write_first", bus_b.Do, 32'h1234FFFF);
    idle(1);

    // pipeline on the latency-2 instance
    for (int i = 0; i < 4; i++) do_req(4'b1111, AL'(i), 32'h10 * (i + 1));
    idle(2);
    for (int i = 0; i < 4; i++) begin
      do_req(4'b0000, AL'(i), 32'h0);
      if (i >= 1) check("pipe_b", bus_b.Do, 32'h10 * i);
    end
    idle(1);
    check("pipe_b_last", bus_b.Do, 32'h40);
    idle(1);
    check("pipe_b_done", 32'(bus_b.RVALID), 32'd0);

    // EN drop with a read in flight
    do_req(4'b0000, 4'd2, 32'h0);
    en = 1'b0;
    #1;
    check("en_drop_ready", 32'(bus_a.REQ_READY), 32'd0);
    step();
    check("en_inflight_b", bus_b.Do, 32'h30);
    step();
    check("en_idle_do", bus_b.Do, 32'h0);
    en = 1'b1;
    idle(1);

    // reset mid-pipeline, then mid-sweep with a read pending
    do_req(4'b0000, 4'd0, 32'h0);
    do_req(4'b0000, 4'd1, 32'h0);
    apply_reset(1);
    repeat (7) step();
    apply_reset(1);
    repeat (DEPTH - 1) step();
    check("resweep_ready_low", 32'(bus_a.REQ_READY), 32'd0);
    step();
    check("resweep_ready_high", 32'(bus_a.REQ_READY), 32'd1);
    idle(3);

    // randomized traffic; an unaccepted request is held unchanged
    last_accepted = 1'b1;
    repeat (600) begin
      if (!req_valid || last_accepted) begin
        req_valid = ($urandom_range(0, 9) < 7);
        we        = ($urandom_range(0, 1) == 1) ? NB'($urandom_range(0, 15)) : '0;
        addr      = AL'($urandom_range(0, DEPTH - 1));
        di        = $urandom;
      end
      en = ($urandom_range(0, 9) < 8);
      step();
    end
    en = 1'b1;
    idle(3);
    check("drain_a", 32'(exp_q_a.size()), 32'd0);
    check("drain_b", 32'(exp_q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
